// File: rtl/key_sequence_checker.sv
// key_sequence_checker
// Captures one cable symbol per rising edge of the synchronised "pulsed"
// strobe and compares the sequence against a programmable key. Failed
// attempts decrement tries_left, and the block locks out when it reaches 0.
// Optional inactivity timeout: define KEYCHK_TIMEOUT_EN.
module key_sequence_checker #(
  parameter int SYM_W       = 2,
  parameter int KEY_LEN     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pulsed,
  input  logic [SYM_W-1:0]                 cables,
  input  logic [KEY_LEN*SYM_W-1:0]         key,
  input  logic                             clear,
  output logic [1:0]                       result,
  output logic [$clog2(KEY_LEN+1)-1:0]     progress,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             sym_ack
);
  localparam int PW = $clog2(KEY_LEN+1);
  localparam int TW = $clog2(MAX_TRIES+1);

  typedef enum logic [1:0] {ENTRY, SUCCESS, FAIL, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   prog_q, prog_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic            mis_q, mis_d;
  logic            ack_q, ack_d;

  // Synchroniser stages; s3 only exists for the strobe edge detector.
  logic             p_s1_q, p_s2_q, p_s3_q;
  logic [SYM_W-1:0] c_s1_q, c_s2_q;

  logic             edge_det;
  logic [SYM_W-1:0] key_sym;
  logic             sym_bad;
  logic             fail_now;

`ifdef KEYCHK_TIMEOUT_EN
  localparam int TMW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC+1) : 1;
  logic [TMW-1:0] tmo_q, tmo_d;
`endif

  assign edge_det = p_s2_q & ~p_s3_q;
  // progress_q is always < KEY_LEN wherever key_sym is used.
  assign key_sym  = key[int'(prog_q)*SYM_W +: SYM_W];
  assign sym_bad  = (c_s2_q != key_sym);

  // Two-flop synchroniser for strobe and cables plus strobe delay for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_s1_q <= 1'b0;
      p_s2_q <= 1'b0;
      p_s3_q <= 1'b0;
      c_s1_q <= '0;
      c_s2_q <= '0;
    end else begin
      p_s1_q <= pulsed;
      p_s2_q <= p_s1_q;
      p_s3_q <= p_s2_q;
      c_s1_q <= cables;
      c_s2_q <= c_s1_q;
    end
  end

  // Next-state: symbol accept/compare, attempt completion, clear and timeout.
  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    tries_d  = tries_q;
    mis_d    = mis_q;
    ack_d    = 1'b0;
    fail_now = 1'b0;
`ifdef KEYCHK_TIMEOUT_EN
    tmo_d    = '0;
`endif
    if (state_q == ENTRY || state_q == FAIL) begin
      if (clear) begin
        // Clear wins over a coincident edge; that edge is dropped.
        state_d = ENTRY;
        prog_d  = '0;
        mis_d   = 1'b0;
      end else if (edge_det) begin
        // From FAIL, progress is already 0 so this starts a fresh attempt.
        ack_d   = 1'b1;
        state_d = ENTRY;
        if (prog_q == PW'(KEY_LEN-1)) begin
          prog_d = '0;
          mis_d  = 1'b0;
          if (!mis_q && !sym_bad) state_d  = SUCCESS;
          else                    fail_now = 1'b1;
        end else begin
          prog_d = prog_q + PW'(1);
          mis_d  = mis_q | sym_bad;
        end
      end
`ifdef KEYCHK_TIMEOUT_EN
      else if (state_q == ENTRY && prog_q != '0) begin
        if (tmo_q == TMW'(TIMEOUT_CYC-1)) begin
          prog_d   = '0;
          mis_d    = 1'b0;
          fail_now = 1'b1;
        end else begin
          tmo_d = tmo_q + TMW'(1);
        end
      end
`endif
    end
    if (fail_now) begin
      tries_d = tries_q - TW'(1);
      state_d = (tries_q == TW'(1)) ? LOCKED : FAIL;
    end
  end

  // State and attempt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      prog_q  <= '0;
      tries_q <= TW'(MAX_TRIES);
      mis_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      tries_q <= tries_d;
      mis_q   <= mis_d;
      ack_q   <= ack_d;
    end
  end

`ifdef KEYCHK_TIMEOUT_EN
  // Inactivity counter; only counts mid-attempt, reloaded by accepts.
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  // Result code decoded straight from the state.
  always_comb begin
    result = 2'b00;
    case (state_q)
      SUCCESS: result = 2'b01;
      FAIL:    result = 2'b10;
      LOCKED:  result = 2'b11;
      default: result = 2'b00;
    endcase
  end

  assign progress   = prog_q;
  assign tries_left = tries_q;
  assign sym_ack    = ack_q;
endmodule

// File: tb/tb_key_sequence_checker.sv
// Directed bench: default checker (key 0,1,2,3) plus a 3-bit / 6-symbol one.
module tb_key_sequence_checker;
  logic       clk = 1'b0;
  logic       reset;
  logic       pa, pb, clra, clrb;
  logic [1:0] ca;
  logic [2:0] cb;
  logic [7:0] keya;
  logic [17:0] keyb;
  logic [1:0] resa, resb;
  logic [2:0] proga, progb;
  logic [1:0] triesa, triesb;
  logic       acka, ackb;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef KEYCHK_TIMEOUT_EN
  key_sequence_checker #(.TIMEOUT_CYC(20)) dut_a (
`else
  key_sequence_checker dut_a (
`endif
    .clk(clk), .reset(reset), .pulsed(pa), .cables(ca), .key(keya), .clear(clra),
    .result(resa), .progress(proga), .tries_left(triesa), .sym_ack(acka));

  key_sequence_checker #(.SYM_W(3), .KEY_LEN(6)) dut_b (
    .clk(clk), .reset(reset), .pulsed(pb), .cables(cb), .key(keyb), .clear(clrb),
    .result(resb), .progress(progb), .tries_left(triesb), .sym_ack(ackb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise the strobe, check the ack three clocks later, drop it, check ack is one cycle.
  task automatic send(input int s, input bit b, input logic exp_ack);
    if (b) begin cb = 3'(s); pb = 1'b1; end
    else   begin ca = 2'(s); pa = 1'b1; end
    repeat (3) @(negedge clk);
    chk("sym_ack", {31'd0, b ? ackb : acka}, {31'd0, exp_ack});
    pa = 1'b0; pb = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, b ? ackb : acka}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    pa = 0; pb = 0; clra = 0; clrb = 0; ca = 0; cb = 0;
    keya = {2'd3, 2'd2, 2'd1, 2'd0};
    keyb = {3'd1, 3'd2, 3'd5, 3'd5, 3'd0, 3'd7};
    do_reset();
    chk("rst_result", resa, 0);
    chk("rst_progress", proga, 0);
    chk("rst_tries", triesa, 3);
    chk("rst_ack", acka, 0);

    // Correct entry
    for (int i = 0; i < 3; i++) begin
      send(i, 0, 1);
      chk("prog_step", proga, i + 1);
      chk("res_hidden", resa, 0);
    end
    send(3, 0, 1);
    chk("ok_result", resa, 1);
    chk("ok_prog", proga, 0);
    chk("ok_tries", triesa, 3);
    send(0, 0, 0);
    chk("success_sticky", resa, 1);

    // Wrong entry then correct
    do_reset();
    for (int i = 0; i < 3; i++) send(3 - i, 0, 1);
    chk("wrong_hidden", resa, 0);
    chk("wrong_prog3", proga, 3);
    send(0, 0, 1);
    chk("wrong_result", resa, 2);
    chk("wrong_tries", triesa, 2);
    send(0, 0, 1);
    chk("retry_res", resa, 0);
    chk("retry_prog", proga, 1);
    for (int i = 1; i < 4; i++) send(i, 0, 1);
    chk("retry_ok", resa, 1);

    // Lockout
    do_reset();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) send(3, 0, 1);
      chk("lock_tries", triesa, 2 - t);
      chk("lock_result", resa, (t == 2) ? 3 : 2);
    end
    send(0, 0, 0);
    chk("locked_prog", proga, 0);
    chk("locked_res", resa, 3);
    do_reset();
    chk("unlock_res", resa, 0);
    chk("unlock_tries", triesa, 3);

    // Clear mid-attempt, then clear coincident with an edge
    send(0, 0, 1);
    send(1, 0, 1);
    clra = 1'b1; @(negedge clk); clra = 1'b0;
    chk("clear_prog", proga, 0);
    chk("clear_tries", triesa, 3);
    ca = 0; pa = 1'b1;
    repeat (2) @(negedge clk);
    clra = 1'b1; @(negedge clk);
    chk("clr_edge_ack", acka, 0);
    clra = 1'b0; pa = 1'b0; @(negedge clk);
    chk("clr_edge_prog", proga, 0);
    chk("clr_edge_ack2", acka, 0);

    // Held strobe yields a single symbol
    ca = 0; pa = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_prog", proga, 1);
    pa = 1'b0;
    clra = 1'b1; @(negedge clk); clra = 1'b0;
    chk("hold_clear", proga, 0);

    // Idle behaviour
    send(0, 0, 1);
`ifdef KEYCHK_TIMEOUT_EN
    repeat (18) @(negedge clk);
    chk("tmo_before", resa, 0);
    @(negedge clk);
    chk("tmo_result", resa, 2);
    chk("tmo_tries", triesa, 2);
    chk("tmo_prog", proga, 0);
    repeat (40) @(negedge clk);
    chk("tmo_idle_res", resa, 2);
    chk("tmo_idle_tries", triesa, 2);
`else
    repeat (40) @(negedge clk);
    chk("idle_prog", proga, 1);
    chk("idle_res", resa, 0);
`endif

    // Wide checker: correct, then last symbol wrong
    do_reset();
    send(7, 1, 1); send(0, 1, 1); send(5, 1, 1); send(5, 1, 1); send(2, 1, 1);
    chk("b_prog5", progb, 5);
    chk("b_hidden", resb, 0);
    send(1, 1, 1);
    chk("b_ok", resb, 1);
    do_reset();
    send(7, 1, 1); send(0, 1, 1); send(5, 1, 1); send(5, 1, 1); send(2, 1, 1);
    send(0, 1, 1);
    chk("b_fail", resb, 2);
    chk("b_tries", triesb, 2);
    chk("b_prog0", progb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
